key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream input stage for the three-colour light top level.
- Takes the raw 2-bit push-button bus from the board pins.
- Synchronises each bit to Sys_CLK, debounces it with a per-channel stable-time counter, and emits clean levels plus single-cycle press/release strobes.
- The light-mode state machine consumes these strobes instead of raw Key bits.

Parameters:
- N_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 50_000, consecutive clock cycles a synchronised input must differ from the stable level before it is accepted (1 ms at 50 MHz). Must be ≥ 2.
- LONG_CYCLES, 50_000_000, cycles a debounced key must stay high before a long-press strobe fires. Used only with KEY_LONGPRESS_EN.

Ports:
- Sys_CLK  in  1  system clock, 50 MHz.
- Sys_RST  in  1  reset; synchronous, active-high.
- Key  in  N_KEYS  raw asynchronous button inputs; 1 = pressed.
- key_level  out  N_KEYS  debounced level per key.
- key_press  out  N_KEYS  one-cycle strobe on an accepted 0→1 transition.
- key_release  out  N_KEYS  one-cycle strobe on an accepted 1→0 transition.
- key_long  out  N_KEYS  one-cycle long-press strobe. Present only with KEY_LONGPRESS_EN.

Behaviour:
- Reset (Sys_RST=1 at a Sys_CLK edge) clears the following to 0:
  - synchroniser flops, counters and stable level;
  - key_level, key_press, key_release and key_long.
- Reset mid-count discards the partial count. A key held high through reset is seen as a fresh press after release of reset plus the full latency below.
- Synchroniser: two flops per bit, ks2 ← ks1 ← Key. No combinational path from Key to any output.
- Per-channel counter `cnt`, width $clog2(DEBOUNCE_CYCLES), with stable level `st`:
  - ks2 == st → cnt ← 0.
  - ks2 != st and cnt < DEBOUNCE_CYCLES−1 → cnt ← cnt+1.
  - ks2 != st and cnt == DEBOUNCE_CYCLES−1 → st ← ks2, cnt ← 0.
- Any glitch back to st before terminal count restarts the count from 0. Pulses shorter than DEBOUNCE_CYCLES are fully rejected.
- key_level = st, registered.
- key_press[i] is high for exactly the one cycle in which st[i] goes 0→1. key_release[i] is the same for 1→0. Both are registered, aligned with the key_level edge, and never high in consecutive cycles.
- Latency: a clean Key edge before clock edge 0 gives a key_level change and strobe at edge 2+DEBOUNCE_CYCLES.
- Channels are fully independent. Simultaneous presses on several keys give simultaneous strobes in the same cycle.
- The counter saturates logically at terminal count, so there is no wrap-around.

Optional Feature:
- Macro: KEY_LONGPRESS_EN.
- Defined:
  - Each channel has a hold counter, width $clog2(LONG_CYCLES+1), cleared while st=0.
  - The hold counter increments while st=1.
  - When it reaches LONG_CYCLES, key_long[i] pulses for one cycle; the counter then holds so there is only one strobe per press.
  - The next press requires release first.
  - Reset clears the hold counter and key_long.
- Undefined: no key_long port, no hold counter logic. All other behaviour is identical.

Decomposition:
- Package key_pkg holds:
  - default constants CLK_HZ=50_000_000, DEBOUNCE_MS=1;
  - derived DEBOUNCE_CYCLES_DEF;
  - LONG_CYCLES_DEF.
- Sub-module key_debounce_ch handles one channel: synchroniser, counter, st, strobes and optional hold counter.
- key_debounce is a generate loop of N_KEYS instances.

Test Plan (bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=32, 20 ns clock):
- Reset with Key=2'b11 held, then release reset → key_level=0 and no strobes during reset. key_press=2'b11 at cycle 10 after reset release, key_level=2'b11 from then.
- Key[0] 0→1 clean → key_press[0]=1 for exactly 1 cycle at edge 10; key_level[0]=1 from edge 10; key_press[1] stays 0.
- Key[0] pulse high for 7 cycles then low → no key_press, key_level[0] stays 0, cnt back to 0.
- Key[1] bounces 1,0,1,0,1 at 3-cycle spacing, then steady 1 → exactly one key_press[1], 10 cycles after the final rising edge.
- Key held 1 then released cleanly → key_release=1 for 1 cycle, 10 cycles after the falling edge; key_level returns to 0.
- KEY_LONGPRESS_EN, Key[0] held 100 cycles → one key_long[0] pulse 32 cycles after key_level[0] rises; none thereafter; a new press after release gives a new pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the push-button input stage.
// Defaults target a 50 MHz system clock with 1 ms debounce.
package key_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 1;

  localparam int unsigned DEBOUNCE_CYCLES_DEF =
    CLK_HZ / 1000 * DEBOUNCE_MS;

  localparam int unsigned LONG_CYCLES_DEF = CLK_HZ;

  typedef struct packed {
    logic level;
    logic press;
    logic rls;
  } key_ev_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stable-time debounce, strobes.
// Optional long-press hold counter under KEY_LONGPRESS_EN.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_LONGPRESS_EN
  , parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
`endif
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    key,
  output key_ev_t ev
`ifdef KEY_LONGPRESS_EN
  , output logic  long_p
`endif
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);

  logic          ks1;
  logic          ks2;
  logic          st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ks1 <= 1'b0;
      ks2 <= 1'b0;
    end else begin
      ks1 <= key;
      ks2 <= ks1;
    end
  end

  // Any sample equal to st restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      st  <= 1'b0;
    end else if (ks2 == st) begin
      cnt <= '0;
    end else if (cnt == CNT_TOP) begin
      st  <= ks2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev <= '0;
    end else begin
      ev.level <= st;
      ev.press <= st & ~ev.level;
      ev.rls   <= ~st & ev.level;
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_TOP = LW'(LONG_CYCLES);

  logic [LW-1:0] hold;
  logic          hit;
  logic          hit_q;

  assign hit = (hold == HOLD_TOP);

  // hold parks at HOLD_TOP, so one strobe per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      hit_q  <= 1'b0;
      long_p <= 1'b0;
    end else begin
      hit_q  <= hit;
      long_p <= hit & ~hit_q;
      if (!st) begin
        hold <= '0;
      end else if (!hit) begin
        hold <= hold + LW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced push-button bus: one key_debounce_ch per key.
// Build option: KEY_LONGPRESS_EN adds the key_long strobe output.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic [N_KEYS-1:0] Key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
`ifdef KEY_LONGPRESS_EN
  , output logic [N_KEYS-1:0] key_long
`endif
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_cfg_err
    $error("key_debounce: DEBOUNCE_CYCLES < 2 or LONG_CYCLES < 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_ev_t ev;

    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_LONGPRESS_EN
      , .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_ch (
      .clk    (Sys_CLK),
      .rst    (Sys_RST),
      .key    (Key[i]),
      .ev     (ev)
`ifdef KEY_LONGPRESS_EN
      , .long_p (key_long[i])
`endif
    );

    assign key_level[i]   = ev.level;
    assign key_press[i]   = ev.press;
    assign key_release[i] = ev.rls;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE_CYCLES=8, LONG_CYCLES=32).
// Strobe edges are timed from the cycle after Key changes.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
`ifdef KEY_LONGPRESS_EN
  logic [1:0] key_long;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0;
  int np[2];
  int nr[2];
  int tp[2];
  int tr[2];
  int nl[2];
  int tl[2];

  always #10 clk = ~clk;

  key_debounce #(
    .N_KEYS          (2),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32)
  ) dut (
    .Sys_CLK     (clk),
    .Sys_RST     (rst),
    .Key         (key),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_LONGPRESS_EN
    , .key_long  (key_long)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      np[k] = 0; nr[k] = 0; tp[k] = -1; tr[k] = -1;
      nl[k] = 0; tl[k] = -1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (key_press[k]) begin np[k]++; tp[k] = cyc; end
        if (key_release[k]) begin nr[k]++; tr[k] = cyc; end
`ifdef KEY_LONGPRESS_EN
        if (key_long[k]) begin
          nl[k]++;
          if (tl[k] < 0) tl[k] = cyc;
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    key = 2'b11;
    clr();
    tick(4);
    chk("rst_level", 32'(key_level), 0);
    chk("rst_press", np[0] + np[1], 0);
    chk("rst_rel", nr[0] + nr[1], 0);
`ifdef KEY_LONGPRESS_EN
    chk("rst_long", nl[0] + nl[1], 0);
`endif

    rst = 1'b0;
    t0 = cyc;
    tick(10);
    chk("post_rst_early", np[0] + np[1], 0);
    tick(1);
    chk("post_rst_press", 32'(key_press), 3);
    chk("post_rst_level", 32'(key_level), 3);
    tick(1);
    chk("post_rst_press_off", 32'(key_press), 0);
    chk("post_rst_level_hold", 32'(key_level), 3);

    clr();
    key = 2'b00;
    t0 = cyc;
    tick(20);
    chk("rel_both_n0", nr[0], 1);
    chk("rel_both_n1", nr[1], 1);
    chk("rel_both_t0", tr[0] - t0, 11);
    chk("rel_both_t1", tr[1] - t0, 11);
    chk("rel_both_level", 32'(key_level), 0);

    clr();
    key = 2'b01;
    t0 = cyc;
    tick(20);
    chk("press0_n", np[0], 1);
    chk("press0_t", tp[0] - t0, 11);
    chk("press0_other", np[1], 0);
    chk("press0_level", 32'(key_level), 1);

    clr();
    key = 2'b00;
    t0 = cyc;
    tick(20);
    chk("rel0_n", nr[0], 1);
    chk("rel0_t", tr[0] - t0, 11);
    chk("rel0_level", 32'(key_level), 0);

    clr();
    key = 2'b01;
    tick(7);
    key = 2'b00;
    tick(1);
    key = 2'b01;
    tick(7);
    key = 2'b00;
    tick(25);
    chk("glitch_press", np[0], 0);
    chk("glitch_level", 32'(key_level), 0);

    clr();
    key = 2'b10; tick(3);
    key = 2'b00; tick(3);
    key = 2'b10; tick(3);
    key = 2'b00; tick(3);
    key = 2'b10;
    t0 = cyc;
    tick(25);
    chk("bounce_n", np[1], 1);
    chk("bounce_t", tp[1] - t0, 11);
    chk("bounce_other", np[0], 0);
    chk("bounce_level", 32'(key_level), 2);

    clr();
    key = 2'b00;
    t0 = cyc;
    tick(20);
    chk("rel1_n", nr[1], 1);
    chk("rel1_t", tr[1] - t0, 11);
    chk("rel1_level", 32'(key_level), 0);

`ifdef KEY_LONGPRESS_EN
    clr();
    key = 2'b01;
    t0 = cyc;
    tick(100);
    chk("long_n", nl[0], 1);
    chk("long_t", tl[0] - t0, 43);
    chk("long_other", nl[1], 0);
    key = 2'b00;
    tick(20);
    clr();
    key = 2'b01;
    t0 = cyc;
    tick(60);
    chk("long2_n", nl[0], 1);
    chk("long2_t", tl[0] - t0, 43);
    key = 2'b00;
    tick(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
